fft_result_reader: RTL and testbench

Unload sequencer at the output end of the FFT stage: once the in-place butterfly passes finish, it reads the N-point result RAM in bit-reversed address order and streams the samples out in natural frequency order over a valid/ready interface. It is the read-side counterpart of the stage index mapping used during the butterfly passes. A 2-entry output buffer absorbs the 1-cycle RAM read latency and downstream backpressure.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_out_fifo2.sv | 40 ++++
 rtl/fft_result_reader.sv | 153 +++++++++++++++
 tb/tb_fft_result_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result unload path: default sizes,
// unload sequencer state encoding and the bit-reversal index map.
package fft_pkg;

  localparam int unsigned MSB_DEF    = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MAX_MSB    = 16;
  localparam int unsigned MAX_IW     = $clog2(MAX_MSB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Mirror bit i to bit w-1-i over the low w bits; upper bits stay zero.
  function automatic logic [MAX_MSB-1:0] bitrev(input logic [MAX_MSB-1:0] v,
                                                input int unsigned        w);
    logic [MAX_MSB-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_MSB; i++) begin
      if (i < w) r[MAX_IW'(w - 1 - i)] = v[MAX_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_fifo2.sv
// Two-entry synchronous FIFO with a fall-through head and an occupancy
// count that the unload sequencer uses for read credit.
module fft_out_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en_i) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (rd_en_i) rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(wr_en_i) - 2'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// Unloads the in-place FFT result RAM in bit-reversed address order and
// streams samples out in natural frequency order over valid/ready.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int unsigned MSB    = MSB_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              natural,
  output logic              busy,
  output logic              done,
  output logic              ram_ren,
  output logic [MSB-1:0]    ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [MSB-1:0]    out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned PW = DATA_W + MSB + 1;

  rd_state_e      state_q;
  logic [MSB-1:0] k_q;
  logic           natural_q;
  logic           busy_q;
  logic           done_q;
  logic           ren_q;
  logic [MSB-1:0] raddr_q;
  logic [MSB-1:0] iss_idx_q;
  logic           iss_last_q;
  logic           ret_q;
  logic [MSB-1:0] ret_idx_q;
  logic           ret_last_q;

  logic [PW-1:0]  fifo_wdata;
  logic [PW-1:0]  fifo_rdata;
  logic [1:0]     fifo_count;
  logic           fifo_has;
  logic           fifo_wr;
  logic           fifo_rd;
  logic           pop;
  logic [1:0]     occ_d;
  logic           credit_ok;
  logic [MSB-1:0] addr_k;

  assign fifo_wdata = {ret_last_q, ret_idx_q, ram_rdata};

  // Head of the buffer: queued entry first, else the read returning this cycle.
  always_comb begin
    fifo_has  = (fifo_count != 2'd0);
    out_valid = fifo_has | ret_q;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (fifo_has) begin
      {out_last, out_index, out_data} = fifo_rdata;
    end else if (ret_q) begin
      {out_last, out_index, out_data} = fifo_wdata;
    end
    pop       = out_valid & out_ready;
    fifo_wr   = ret_q & (fifo_has | ~out_ready);
    fifo_rd   = pop & fifo_has;
    occ_d     = fifo_count + 2'(ret_q) - 2'(pop);
    credit_ok = (3'(occ_d) + 3'(ren_q)) < 3'd2;
    addr_k    = natural_q ? k_q : MSB'(bitrev(MAX_MSB'(k_q), MSB));
  end

  fft_out_fifo2 #(.W(PW)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      natural_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ren_q      <= 1'b0;
      raddr_q    <= '0;
      iss_idx_q  <= '0;
      iss_last_q <= 1'b0;
      ret_q      <= 1'b0;
      ret_idx_q  <= '0;
      ret_last_q <= 1'b0;
    end else begin
      ret_q <= ren_q;
      if (ren_q) begin
        ret_idx_q  <= iss_idx_q;
        ret_last_q <= iss_last_q;
      end
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          ren_q  <= 1'b0;
          if (start) begin
            state_q    <= ST_RUN;
            natural_q  <= natural;
            busy_q     <= 1'b1;
            ren_q      <= 1'b1;
            raddr_q    <= '0;
            iss_idx_q  <= '0;
            iss_last_q <= 1'b0;
            k_q        <= MSB'(1);
          end
        end
        ST_RUN: begin
          if (credit_ok) begin
            ren_q      <= 1'b1;
            raddr_q    <= addr_k;
            iss_idx_q  <= k_q;
            iss_last_q <= &k_q;
            k_q        <= k_q + MSB'(1);
            if (&k_q) state_q <= ST_DRAIN;
          end else begin
            ren_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          ren_q <= 1'b0;
          // Last read must have returned and been taken by downstream.
          if (!ren_q && occ_d == 2'd0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_ren   = ren_q;
  assign ram_raddr = raddr_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: 8-point and 256-point instances, each with a
// 1-cycle registered-read RAM, checked against an index/order reference model.
module tb_fft_result_reader;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-point instance
  logic        s3, nat3, busy3, done3, ren3, valid3, ready3, last3;
  logic [2:0]  raddr3, idx3;
  logic [31:0] rdata3 = '0;
  logic [31:0] data3;
  logic [31:0] mem3 [8];

  // 256-point instance
  logic        s8, nat8, busy8, done8, ren8, valid8, ready8, last8;
  logic [7:0]  raddr8, idx8;
  logic [31:0] rdata8 = '0;
  logic [31:0] data8;
  logic [31:0] mem8 [256];

  always @(posedge clk) if (ren3) rdata3 <= mem3[raddr3];
  always @(posedge clk) if (ren8) rdata8 <= mem8[raddr8];

  fft_result_reader #(.MSB(3), .DATA_W(32)) dut3 (
    .clk(clk), .reset(reset), .start(s3), .natural(nat3), .busy(busy3), .done(done3),
    .ram_ren(ren3), .ram_raddr(raddr3), .ram_rdata(rdata3), .out_data(data3),
    .out_index(idx3), .out_valid(valid3), .out_ready(ready3), .out_last(last3));

  fft_result_reader #(.MSB(8), .DATA_W(32)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .natural(nat8), .busy(busy8), .done(done8),
    .ram_ren(ren8), .ram_raddr(raddr8), .ram_rdata(rdata8), .out_data(data8),
    .out_index(idx8), .out_valid(valid8), .out_ready(ready8), .out_last(last8));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (((v >> i) & 1) != 0) r |= (1 << (w - 1 - i));
    return r;
  endfunction

  function automatic int exp_addr(input int k, input bit nat, input int w);
    return nat ? k : brev(k, w);
  endfunction

  function automatic logic ready_for(input int mode, input int rel);
    if (mode == 1) return ((rel - 1) % 4 == 0) || ((rel - 1) % 4 == 3);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic check_idle3(input string tag);
    check_eq({tag, "_busy"},  busy3,  0);
    check_eq({tag, "_done"},  done3,  0);
    check_eq({tag, "_ren"},   ren3,   0);
    check_eq({tag, "_raddr"}, raddr3, 0);
    check_eq({tag, "_valid"}, valid3, 0);
    check_eq({tag, "_last"},  last3,  0);
    check_eq({tag, "_data"},  data3,  0);
    check_eq({tag, "_index"}, idx3,   0);
  endtask

  // mode 0: ready held high, 1: 1,0,0,1 pattern, 2: random
  task automatic run3(input bit nat, input int mode, input bit repulse);
    int issued = 0;
    int acc = 0;
    int done_rel = 0;
    bit prev_stall = 0;
    logic [31:0] pd = '0;
    logic [2:0]  pi = '0;
    @(posedge clk); #1;
    s3 = 1'b1; nat3 = nat; ready3 = 1'b1;
    for (int rel = 1; rel < 200 && done_rel == 0; rel++) begin
      @(posedge clk); #1;
      s3 = repulse && (rel == 4);
      nat3 = ~nat;
      ready3 = ready_for(mode, rel);
      @(negedge clk);
      if (ren3) begin
        if (issued == 0) check_eq("first_ren_cycle", rel, 1);
        check_eq("raddr", raddr3, exp_addr(issued, nat, 3));
        issued++;
        check_eq("credit", (issued - acc) <= 2, 1);
      end
      if (prev_stall) begin
        check_eq("hold_valid", valid3, 1);
        check_eq("hold_data", data3, pd);
        check_eq("hold_index", idx3, pi);
      end
      if (valid3 && ready3) begin
        if (mode == 0) check_eq("beat_cycle", rel, acc + 2);
        check_eq("out_index", idx3, acc);
        check_eq("out_data", data3, mem3[exp_addr(acc, nat, 3)]);
        check_eq("out_last", last3, acc == 7);
        acc++;
      end
      prev_stall = valid3 && !ready3;
      pd = data3;
      pi = idx3;
      if (done3) begin
        done_rel = rel;
        check_eq("beats_at_done", acc, 8);
        check_eq("reads_at_done", issued, 8);
        if (mode == 0) check_eq("done_cycle", rel, 10);
      end
    end
    check_eq("done_seen", done_rel != 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("done_single", done3, 0);
    check_eq("busy_after", busy3, 0);
    check_eq("valid_after", valid3, 0);
  endtask

  task automatic reset_mid();
    int acc = 0;
    @(posedge clk); #1;
    s3 = 1'b1; nat3 = 1'b0; ready3 = 1'b1;
    for (int c = 0; c < 50 && acc < 3; c++) begin
      @(posedge clk); #1;
      s3 = 1'b0;
      @(negedge clk);
      if (valid3 && ready3) acc++;
    end
    check_eq("pre_reset_beats", acc, 3);
    @(posedge clk); #1;
    ready3 = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_reset_busy", busy3, 1);
    reset = 1'b1;
    #1;
    check_idle3("rst_async");
    @(negedge clk);
    check_idle3("rst_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    ready3 = 1'b1;
    @(negedge clk);
    check_idle3("rst_after");
  endtask

  task automatic run8();
    int q[$];
    int acc = 0;
    int done_rel = 0;
    int a;
    @(posedge clk); #1;
    s8 = 1'b1; nat8 = 1'b0; ready8 = 1'b1;
    for (int rel = 1; rel < 400 && done_rel == 0; rel++) begin
      @(posedge clk); #1;
      s8 = 1'b0;
      @(negedge clk);
      if (ren8) q.push_back(int'(raddr8));
      if (valid8 && ready8) begin
        check_eq("b8_cycle", rel, acc + 2);
        if (q.size() == 0) begin
          check_eq("b8_read_before_beat", 0, 1);
        end else begin
          a = q.pop_front();
          check_eq("b8_index_bitrev", idx8, brev(a, 8));
          check_eq("b8_index", idx8, acc);
          check_eq("b8_data", data8, mem8[a]);
          check_eq("b8_last", last8, acc == 255);
        end
        acc++;
      end
      if (done8) begin
        done_rel = rel;
        check_eq("b8_done_cycle", rel, 258);
        check_eq("b8_beats", acc, 256);
      end
    end
    check_eq("b8_done_seen", done_rel != 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("b8_busy_after", busy8, 0);
  endtask

  initial begin
    reset = 1'b1;
    s3 = 1'b0; nat3 = 1'b0; ready3 = 1'b0;
    s8 = 1'b0; nat8 = 1'b0; ready8 = 1'b0;
    for (int a = 0; a < 8; a++) mem3[a] = 32'(a * 16);
    for (int a = 0; a < 256; a++) mem8[a] = $urandom;
    repeat (2) @(negedge clk);
    check_idle3("reset");
    check_eq("reset8_valid", valid8, 0);
    check_eq("reset8_busy", busy8, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);

    run3(1'b0, 0, 1'b0);
    run3(1'b1, 0, 1'b0);
    run3(1'b0, 1, 1'b0);
    run3(1'b0, 0, 1'b1);
    reset_mid();
    run3(1'b0, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 8; a++) mem3[a] = $urandom;
      run3(1'($urandom_range(0, 1)), 2, 1'b0);
    end

    run8();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
